// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative multiplier.
// Imported by the interface, datapath and top-level files.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int N_DEF = 8;
  localparam int CNT_W_DEF = $clog2(N_DEF);

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Valid/ready bundle between producer, multiplier and consumer.
// master drives operands and out_ready; slave is the multiplier.
interface seq_multiplier_if #(
  parameter int N = 8
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic           busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/seq_multiplier_ripple_adder.sv
// W-bit ripple-carry adder used as the single shift-add step adder.
// Carry-in exposed so callers can reuse it for increments.
module ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative N x N -> 2N shift-add multiplier, signed or unsigned.
// Multiplies magnitudes, then negates the product when signs differ.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_multiplier_if.slave  bus
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [N:0]     hi;
  logic [N-1:0]   lo;
  logic [N-1:0]   mcand;
  logic           neg;
  logic [CW-1:0]  cnt;

  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [2*N-1:0] p_q;

  logic [N-1:0]   sum;
  logic           cout;
  logic [N:0]     acc;
  logic [N-1:0]   lo_nx;
  logic [2*N-1:0] prod;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           neg_in;

  ripple_adder #(
    .W (N)
  ) u_add (
    .a    (hi[N-1:0]),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // -2^(N-1) negates to 2^(N-1), which is exact as N-bit unsigned
  always_comb begin
    a_mag  = (bus.is_signed & bus.a[N-1]) ? -bus.a : bus.a;
    b_mag  = (bus.is_signed & bus.b[N-1]) ? -bus.b : bus.b;
    neg_in = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
  end

  always_comb begin
    acc   = lo[0] ? {cout, sum} : hi;
    lo_nx = {acc[0], lo[N-1:1]};
    prod  = {acc[N:1], lo_nx};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      p_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= BUSY;
            mcand      <= a_mag;
            lo         <= b_mag;
            neg        <= neg_in;
            hi         <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          hi  <= {1'b0, acc[N:1]};
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            p_q         <= neg ? -prod : prod;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at N=8 and N=4.
// Expected products are hand-computed constants.
module tb_seq_multiplier;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  seq_multiplier_if #(.N(8)) m8 ();
  seq_multiplier_if #(.N(4)) m4 ();

  seq_multiplier #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m8)
  );

  seq_multiplier #(.N(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp,
                     input string tag, input bit toggle);
    int n;
    @(negedge clk);
    m8.a = a;
    m8.b = b;
    m8.is_signed = s;
    m8.in_valid = 1'b1;
    m8.out_ready = 1'b0;
    @(posedge clk);
    #1;
    m8.in_valid = 1'b0;
    n = 0;
    while (!m8.out_valid && n < 40) begin
      if (toggle) begin
        m8.a = 8'($urandom);
        m8.b = 8'($urandom);
        m8.is_signed = 1'($urandom);
        m8.in_valid = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    m8.in_valid = 1'b0;
    check({tag, " latency"}, n, 8);
    check({tag, " p"}, m8.p, exp);
  endtask

  task automatic done8(input string tag);
    @(negedge clk);
    m8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " ov_drop"}, m8.out_valid, 0);
    check({tag, " in_ready"}, m8.in_ready, 1);
    m8.out_ready = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic s, input logic [7:0] exp,
                     input string tag);
    int n;
    @(negedge clk);
    m4.a = a;
    m4.b = b;
    m4.is_signed = s;
    m4.in_valid = 1'b1;
    m4.out_ready = 1'b0;
    @(posedge clk);
    #1;
    m4.in_valid = 1'b0;
    n = 0;
    while (!m4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " p"}, m4.p, exp);
    @(negedge clk);
    m4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m4.out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    int na;
    int t[3];

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    m8.in_valid = 1'b0;
    m8.a = '0;
    m8.b = '0;
    m8.is_signed = 1'b0;
    m8.out_ready = 1'b0;
    m4.in_valid = 1'b0;
    m4.a = '0;
    m4.b = '0;
    m4.is_signed = 1'b0;
    m4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", m8.in_ready, 1);
    check("rst out_valid", m8.out_valid, 0);
    check("rst busy", m8.busy, 0);
    check("rst p", m8.p, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255", 1'b0);
    check("done busy", m8.busy, 1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m8.in_valid = 1'($urandom);
      m8.a = 8'($urandom);
      @(posedge clk);
      #1;
      ok &= (m8.p === 16'hFE01) && (m8.in_ready === 1'b0)
          && (m8.out_valid === 1'b1);
    end
    m8.in_valid = 1'b0;
    check("hold stable", ok, 1);
    done8("u255x255");

    op8(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128", 1'b0);
    done8("s-128x-128");
    op8(8'h80, 8'h7F, 1'b1, 16'hC080, "s-128x127", 1'b0);
    done8("s-128x127");
    op8(8'h05, 8'h00, 1'b1, 16'h0000, "s5x0", 1'b0);
    done8("s5x0");
    op8(8'h80, 8'h80, 1'b0, 16'h4000, "u128x128", 1'b1);
    done8("u128x128");
    op8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s-3x7", 1'b0);
    done8("s-3x7");

    @(negedge clk);
    m8.a = 8'd200;
    m8.b = 8'd100;
    m8.is_signed = 1'b0;
    m8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    m8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst in_ready", m8.in_ready, 1);
    check("midrst out_valid", m8.out_valid, 0);
    check("midrst busy", m8.busy, 0);
    check("midrst p", m8.p, 0);
    rst_n = 1'b1;
    op8(8'd3, 8'd7, 1'b0, 16'd21, "u3x7", 1'b0);
    done8("u3x7");

    @(negedge clk);
    m8.a = 8'd3;
    m8.b = 8'd4;
    m8.is_signed = 1'b0;
    m8.out_ready = 1'b1;
    m8.in_valid = 1'b1;
    na = 0;
    n = 0;
    while (na < 3 && n < 60) begin
      if (m8.in_ready && m8.in_valid) begin
        t[na] = cyc;
        na++;
      end
      if (na < 3) @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    m8.in_valid = 1'b0;
    check("tput accepts", na, 3);
    check("tput gap1", t[1] - t[0], 10);
    check("tput gap2", t[2] - t[1], 10);
    n = 0;
    while (!m8.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tput p", m8.p, 16'd12);
    @(negedge clk);
    m8.out_ready = 1'b0;

    op4(4'h8, 4'h8, 1'b1, 8'h40, "n4 s-8x-8");
    op4(4'h8, 4'h7, 1'b1, 8'hC8, "n4 s-8x7");
    op4(4'hF, 4'hF, 1'b0, 8'hE1, "n4 u15x15");
    op4(4'hF, 4'h3, 1'b1, 8'hFD, "n4 s-1x3");
    op4(4'hF, 4'hF, 1'b1, 8'h01, "n4 s-1x-1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
